pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage sequencer that owns the program counter register and drives the instruction-memory request handshake. Every cycle it selects the next PC from these sources: sequential PC+4, the decode-stage jump inputs (same 2-bit jump encoding as the PC adder), and the execute-stage branch redirect. It handles memory wait states, pipeline stalls and redirects that arrive while a fetch is outstanding, and it delivers registered fetch results to the IF/ID register.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded at reset
- TRAP_VECTOR, 32'h0000_0080, PC loaded on a misaligned target (see Configuration)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard-unit stall; IF/ID must not advance
- jump  in  2  01/11 selects jump_add, 10 selects jump_forward_add, 00 means no jump
- jump_add  in  32  decode jump target
- jump_forward_add  in  32  forwarded jump target
- br_taken  in  1  execute-stage branch taken
- br_target  in  32  branch target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, always equal to the PC register
- imem_ack  in  1  data valid this cycle; may be high in the same cycle as imem_req
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  if_pc and if_instr hold a live instruction
- if_pc  out  32  PC of the delivered instruction
- if_instr  out  32  delivered instruction
- flush  out  1  one-cycle pulse that kills the younger instruction in IF/ID
- trap  out  1  one-cycle misalign pulse
- bad_addr  out  32  last misaligned target

## Operation
- States: BOOT, FETCH, HOLD.
- Reset values: state=BOOT, pc=RESET_VECTOR, imem_req=0, if_valid=0, if_pc=0, if_instr=0, flush=0, trap=0, bad_addr=0, pend_v=0, pend_addr=0.
- Redirect priority: br_taken, then jump≠00. A redirect target is br_target, or jump_add / jump_forward_add per the jump encoding. Any redirect asserts flush on the next cycle.
- BOOT: imem_req=0. Go to FETCH. A redirect seen in BOOT loads pc.
- FETCH: imem_req=1 until ack. A request is never retracted once raised.
  - ack, no redirect, pend_v=0: capture if_pc=pc and if_instr=imem_rdata, set if_valid=1, pc←pc+4 (mod 2^32). Stay in FETCH if stall=0; go to HOLD if stall=1.
  - ack with a redirect this cycle: drop the data (if_valid←0), pc←target, clear pend_v, stay in FETCH.
  - ack with pend_v=1 and no new redirect: drop the data, pc←pend_addr, clear pend_v.
  - No ack but a redirect: pend_v←1, pend_addr←target (a newer redirect overwrites). pc is unchanged until ack.
- While FETCH is waiting, if_valid←0 once the consumer has taken the previous instruction (stall=0).
- HOLD: imem_req=0, if_valid held with stable data.
  - stall falls: go to FETCH at pc; if_valid drops the following cycle unless a new ack arrives.
  - Redirect in HOLD: if_valid←0, pc←target, go to FETCH.
- Consumer contract: an instruction is consumed on any cycle with if_valid=1 and stall=0.

## Timing
- Fetch latency: imem_ack edge to if_valid=1 is one cycle, registered.
- Zero-wait memory with stall=0 sustains one instruction per cycle: addresses pc, pc+4, pc+8 on consecutive cycles.
- Redirect to first fetch at the target: next cycle if no fetch is outstanding; otherwise the cycle after the outstanding ack.
- flush is exactly one cycle wide, including for back-to-back redirects on consecutive cycles.
- rst_n assertion mid-fetch aborts immediately. A late imem_ack after reset is ignored in BOOT.

## Configuration
- PC_SEQ_MISALIGN_TRAP_EN defined: any redirect target with [1:0]≠0 loads pc=TRAP_VECTOR (not the target), sets bad_addr=target, pulses trap for one cycle, and still asserts flush. The same rule applies to pending redirects.
- Undefined: target[1:0] is forced to 00; trap and bad_addr are tied to 0.

## Test plan
- Reset then zero-wait memory (ack tied high), no stall → imem_addr 0x0, 0x4, 0x8; if_pc 0x0 appears one cycle after the first request.
- Two-cycle ack latency with br_taken=1, br_target=0x200 in the first wait cycle → the fetched data is dropped, the next imem_addr is 0x200, flush pulses for one cycle.
- stall=1 when the ack at 0x10 arrives → state HOLD, imem_req=0, if_pc=0x10 stable for 3 stall cycles, then fetch resumes at 0x14.
- jump=10, jump_forward_add=0x40 in the same cycle as br_taken with target 0x80 → pc=0x80; jump=11 alone with jump_add=0x44 → pc=0x44.
- With PC_SEQ_MISALIGN_TRAP_EN, br_target=0x102 → pc=0x80, trap=1 for one cycle, bad_addr=0x102. Without the macro → pc=0x100.
- rst_n low during an outstanding fetch → pc=0x0, imem_req=0, if_valid=0 immediately; a stale ack in BOOT produces no if_valid.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: owns the PC, drives the imem request handshake and feeds IF/ID.
// Optional misaligned-redirect trap enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    , parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  jump,
    input  logic [31:0] jump_add,
    input  logic [31:0] jump_forward_add,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        trap,
    output logic [31:0] bad_addr
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        pend_v_reg, pend_v_next;
    logic [31:0] pend_addr_reg, pend_addr_next;
    logic        if_valid_reg, if_valid_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_instr_reg, if_instr_next;
    logic        flush_reg;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;

    // Branch from execute outranks the decode-stage jump.
    always_comb begin
        redirect   = br_taken || (jump != 2'b00);
        raw_target = br_target;
        if (!br_taken) begin
            raw_target = (jump == 2'b10) ? jump_forward_add : jump_add;
        end
    end

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic        misaligned;
    logic        trap_reg;
    logic [31:0] bad_addr_reg;

    assign misaligned = redirect && (raw_target[1:0] != 2'b00);
    assign target     = misaligned ? TRAP_VECTOR : raw_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_reg     <= 1'b0;
            bad_addr_reg <= '0;
        end else begin
            trap_reg <= misaligned;
            if (misaligned) begin
                bad_addr_reg <= raw_target;
            end
        end
    end

    assign trap     = trap_reg;
    assign bad_addr = bad_addr_reg;
`else
    assign target   = raw_target & 32'hFFFF_FFFC;
    assign trap     = 1'b0;
    assign bad_addr = '0;
`endif

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        pend_v_next    = pend_v_reg;
        pend_addr_next = pend_addr_reg;
        if_valid_next  = if_valid_reg;
        if_pc_next     = if_pc_reg;
        if_instr_next  = if_instr_reg;
        case (state_reg)
            BOOT: begin
                state_next = FETCH;
                if (redirect) begin
                    pc_next = target;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        if_valid_next = 1'b0;
                        pc_next       = target;
                        pend_v_next   = 1'b0;
                    end else if (pend_v_reg) begin
                        // Data belongs to the path a redirect already abandoned.
                        if_valid_next = 1'b0;
                        pc_next       = pend_addr_reg;
                        pend_v_next   = 1'b0;
                    end else begin
                        if_valid_next = 1'b1;
                        if_pc_next    = pc_reg;
                        if_instr_next = imem_rdata;
                        pc_next       = pc_reg + 32'd4;
                        if (stall) begin
                            state_next = HOLD;
                        end
                    end
                end else begin
                    // Request stays up on the old address; remember where to go.
                    if (redirect) begin
                        pend_v_next    = 1'b1;
                        pend_addr_next = target;
                    end
                    if (!stall) begin
                        if_valid_next = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_valid_next = 1'b0;
                    pc_next       = target;
                    state_next    = FETCH;
                end else if (!stall) begin
                    if_valid_next = 1'b0;
                    state_next    = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_VECTOR;
            pend_v_reg    <= 1'b0;
            pend_addr_reg <= '0;
            if_valid_reg  <= 1'b0;
            if_pc_reg     <= '0;
            if_instr_reg  <= '0;
            flush_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            pend_v_reg    <= pend_v_next;
            pend_addr_reg <= pend_addr_next;
            if_valid_reg  <= if_valid_next;
            if_pc_reg     <= if_pc_next;
            if_instr_reg  <= if_instr_next;
            // Back-to-back redirects still yield a single-cycle pulse.
            flush_reg     <= redirect && !flush_reg;
        end
    end

    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign if_valid  = if_valid_reg;
    assign if_pc     = if_pc_reg;
    assign if_instr  = if_instr_reg;
    assign flush     = flush_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard of delivered instructions.
module tb_pc_sequencer;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [1:0]  jump;
    logic [31:0] jump_add;
    logic [31:0] jump_forward_add;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        trap;
    logic [31:0] bad_addr;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t sb_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   prev_valid = 1'b0;
    logic   prev_stall = 1'b0;

    pc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .jump             (jump),
        .jump_add         (jump_add),
        .jump_forward_add (jump_forward_add),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .flush            (flush),
        .trap             (trap),
        .bad_addr         (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mk_instr(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        fetch_t e;
        e.pc    = a;
        e.instr = mk_instr(a);
        sb_q.push_back(e);
    endtask

    // A delivered instruction is new unless the previous cycle held it under stall.
    always @(negedge clk) begin
        fetch_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (if_valid && !(prev_valid && prev_stall)) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                end else begin
                    e.pc    = 32'hFFFF_FFFF;
                    e.instr = 32'hFFFF_FFFF;
                end
                $display("txn if_pc=%h if_instr=%h exp_pc=%h", if_pc, if_instr, e.pc);
                check("sb_pc", if_pc, e.pc);
                check("sb_instr", if_instr, e.instr);
            end
            prev_valid = if_valid;
            prev_stall = stall;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mis_pc;
        rst_n = 1'b0; stall = 1'b0; jump = 2'b00; jump_add = '0; jump_forward_add = '0;
        br_taken = 1'b0; br_target = '0; imem_ack = 1'b0;
        tick();
        tick();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_trap", {31'b0, trap}, 32'd0);
        check("rst_bad_addr", bad_addr, 32'h0);

        // Zero-wait streaming
        rst_n = 1'b1; imem_ack = 1'b1;
        check("boot_req", {31'b0, imem_req}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("stream_req", {31'b0, imem_req}, 32'd1);
            check("stream_addr", imem_addr, 32'(i * 4));
            expect_fetch(32'(i * 4));
            tick();
        end
        imem_ack = 1'b0;
        check("stream_next_addr", imem_addr, 32'hC);

        // Branch during a wait cycle
        br_taken = 1'b1; br_target = 32'h200;
        tick();
        check("wait_flush", {31'b0, flush}, 32'd1);
        check("wait_addr_hold", imem_addr, 32'hC);
        check("wait_valid", {31'b0, if_valid}, 32'd0);
        br_taken = 1'b0; imem_ack = 1'b1;
        tick();
        check("wait_flush_end", {31'b0, flush}, 32'd0);
        check("wait_redirect_addr", imem_addr, 32'h200);
        check("wait_drop_valid", {31'b0, if_valid}, 32'd0);

        // Reach 0x10 via a pending jump, then stall at its ack
        expect_fetch(32'h200);
        tick();
        imem_ack = 1'b0; jump = 2'b01; jump_add = 32'h10;
        tick();
        check("jump_flush", {31'b0, flush}, 32'd1);
        jump = 2'b00; imem_ack = 1'b1;
        tick();
        check("jump_addr", imem_addr, 32'h10);
        stall = 1'b1;
        expect_fetch(32'h10);
        tick();
        imem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("hold_req", {31'b0, imem_req}, 32'd0);
            check("hold_valid", {31'b0, if_valid}, 32'd1);
            check("hold_if_pc", if_pc, 32'h10);
            tick();
        end
        stall = 1'b0;
        tick();
        check("resume_req", {31'b0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'h14);
        check("resume_valid", {31'b0, if_valid}, 32'd0);

        // Priority: branch beats jump; jump=11 selects jump_add
        imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h80;
        jump = 2'b10; jump_forward_add = 32'h40;
        tick();
        check("prio_addr", imem_addr, 32'h80);
        check("prio_flush", {31'b0, flush}, 32'd1);
        br_taken = 1'b0; jump = 2'b11; jump_add = 32'h44;
        tick();
        check("jump11_addr", imem_addr, 32'h44);
        jump = 2'b00; imem_ack = 1'b0;
        tick();
        check("idle_flush", {31'b0, flush}, 32'd0);
        check("idle_addr", imem_addr, 32'h44);

        // Misaligned branch target
        imem_ack = 1'b1; br_taken = 1'b1; br_target = 32'h102;
        tick();
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        mis_pc = 32'h80;
        check("mis_addr", imem_addr, mis_pc);
        check("mis_trap", {31'b0, trap}, 32'd1);
        check("mis_bad_addr", bad_addr, 32'h102);
`else
        mis_pc = 32'h100;
        check("mis_addr", imem_addr, mis_pc);
        check("mis_trap", {31'b0, trap}, 32'd0);
        check("mis_bad_addr", bad_addr, 32'h0);
`endif
        check("mis_flush", {31'b0, flush}, 32'd1);
        br_taken = 1'b0; imem_ack = 1'b0;
        tick();
        check("mis_trap_end", {31'b0, trap}, 32'd0);

        // Reset during an outstanding fetch
        imem_ack = 1'b1;
        expect_fetch(mis_pc);
        tick();
        imem_ack = 1'b0;
        check("pre_rst_valid", {31'b0, if_valid}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_req", {31'b0, imem_req}, 32'd0);
        check("async_addr", imem_addr, 32'h0);
        check("async_valid", {31'b0, if_valid}, 32'd0);
        imem_ack = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("stale_valid", {31'b0, if_valid}, 32'd0);
        check("stale_addr", imem_addr, 32'h0);
        check("stale_req", {31'b0, imem_req}, 32'd1);
        tick();
        check("stale_valid2", {31'b0, if_valid}, 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
